// File: rtl/w_io_pkg.sv
// West IO tile shared definitions.
// Per-channel config field offsets and input capture modes.
package w_io_pkg;

    localparam int CFG_BITS_PER_CH = 12;

    localparam int OUT_REG_B   = 0;
    localparam int OE_REG_B    = 1;
    localparam int IN_MODE_LSB = 2;
    localparam int INV_OUT_B   = 4;
    localparam int INV_IN_B    = 5;
    localparam int OE_FORCE_B  = 6;
    localparam int RSVD_B      = 7;
    localparam int CFGC_LSB    = 8;

    typedef enum logic [1:0] {
        IN_COMB = 2'd0,
        IN_REG  = 2'd1,
        IN_SYNC = 2'd2,
        IN_EDGE = 2'd3
    } in_mode_e;

endpackage

// File: rtl/w_io_chan.sv
// One fabric-to-pad IO channel.
// Output/OE registers, input capture pipeline and reset gating.
module w_io_chan
    import w_io_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [CFG_BITS_PER_CH-1:0] cfg,
    input  logic                       pad_o,
    input  logic                       fab_i,
    input  logic                       fab_t,
    output logic                       pad_i,
    output logic                       pad_t,
    output logic                       fab_o,
    output logic [3:0]                 config_c
);

    in_mode_e mode;
    logic     x;
    logic     d;
    logic     t;
    logic     q_out;
    logic     q_t;
    logic     s1;
    logic     s2;
    logic     s3;
    logic     fab_sel;
    logic     unused_rsvd;

    assign mode        = in_mode_e'(cfg[IN_MODE_LSB +: 2]);
    assign x           = pad_o ^ cfg[INV_IN_B];
    assign d           = fab_i ^ cfg[INV_OUT_B];
    assign t           = cfg[OE_REG_B] ? q_t : fab_t;
    assign unused_rsvd = cfg[RSVD_B];

    // Capture pipeline runs in every mode so a mode switch needs no flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_out <= 1'b0;
            q_t   <= 1'b0;
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
        end else begin
            q_out <= d;
            q_t   <= fab_t;
            s1    <= x;
            s2    <= s1;
            s3    <= s2;
        end
    end

    always_comb begin
        fab_sel = x;
        unique case (1'b1)
            mode == IN_REG:  fab_sel = s1;
            mode == IN_SYNC: fab_sel = s2;
            mode == IN_EDGE: fab_sel = s2 & ~s3;
            default:         fab_sel = x;
        endcase
    end

    assign pad_i    = rst_n & (cfg[OUT_REG_B] ? q_out : d);
    assign pad_t    = ~rst_n | (~cfg[OE_FORCE_B] & t);
    assign fab_o    = rst_n & fab_sel;
    assign config_c = rst_n ? cfg[CFGC_LSB +: 4] : 4'h0;

endmodule

// File: rtl/w_io_multi.sv
// Parametrised west-edge IO tile with NUM_CH channels.
// Holds the frame config store and the frame/clock passthroughs.
module w_io_multi #(
    parameter int NUM_CH          = 4,
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int CFG_BITS_PER_CH = 12
) (
    input  logic                       UserCLK,
    input  logic                       UserRST_n,
    input  logic [NUM_CH-1:0]          pad_O,
    output logic [NUM_CH-1:0]          pad_I,
    output logic [NUM_CH-1:0]          pad_T,
    input  logic [NUM_CH-1:0]          fab_I,
    input  logic [NUM_CH-1:0]          fab_T,
    output logic [NUM_CH-1:0]          fab_O,
    output logic [4*NUM_CH-1:0]        Config_C,
    output logic                       UserCLKo,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    output logic [FrameBitsPerRow-1:0] FrameData_O,
    input  logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic [MaxFramesPerCol-1:0] FrameStrobe_O
);

    localparam int USED_W     = CFG_BITS_PER_CH * NUM_CH;
    localparam int NUM_FRAMES = (USED_W + FrameBitsPerRow - 1) / FrameBitsPerRow;
    localparam int CFG_W      = NUM_FRAMES * FrameBitsPerRow;

    if (CFG_BITS_PER_CH != w_io_pkg::CFG_BITS_PER_CH) begin : g_err_cfg
        $error("CFG_BITS_PER_CH is fixed at 12");
    end
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_err_ch
        $error("NUM_CH must be in 1..16");
    end
    if (NUM_FRAMES > MaxFramesPerCol) begin : g_err_frames
        $error("NUM_FRAMES exceeds MaxFramesPerCol");
    end

    logic [FrameBitsPerRow-1:0] frame_q [NUM_FRAMES];
    logic [CFG_W-1:0]           cfg;

    // Reset takes priority over any strobe in the same cycle.
    always_ff @(posedge UserCLK) begin
        for (int f = 0; f < NUM_FRAMES; f++) begin
            if (!UserRST_n) begin
                frame_q[f] <= '0;
            end else if (FrameStrobe[f]) begin
                frame_q[f] <= FrameData;
            end
        end
    end

    for (genvar f = 0; f < NUM_FRAMES; f++) begin : g_pack
        assign cfg[f*FrameBitsPerRow +: FrameBitsPerRow] = frame_q[f];
    end

    if (CFG_W > USED_W) begin : g_spare
        logic unused_cfg;
        assign unused_cfg = ^cfg[CFG_W-1:USED_W];
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        w_io_chan u_chan (
            .clk      (UserCLK),
            .rst_n    (UserRST_n),
            .cfg      (cfg[c*CFG_BITS_PER_CH +: CFG_BITS_PER_CH]),
            .pad_o    (pad_O[c]),
            .fab_i    (fab_I[c]),
            .fab_t    (fab_T[c]),
            .pad_i    (pad_I[c]),
            .pad_t    (pad_T[c]),
            .fab_o    (fab_O[c]),
            .config_c (Config_C[4*c +: 4])
        );
    end

    assign UserCLKo      = UserCLK;
    assign FrameData_O   = FrameData;
    assign FrameStrobe_O = FrameStrobe;

endmodule

// File: tb/tb_w_io_multi.sv
// Self-checking bench for w_io_multi.
// Random stimulus against a cycle-history reference model.
module tb_w_io_multi;

    localparam int NUM_CH = 4;
    localparam int FBPR   = 32;
    localparam int MFPC   = 20;
    localparam int NF     = (12*NUM_CH + FBPR - 1) / FBPR;
    localparam int OW     = 7*NUM_CH;

    logic                UserCLK = 1'b0;
    logic                UserRST_n;
    logic [NUM_CH-1:0]   pad_O, pad_I, pad_T, fab_I, fab_T, fab_O;
    logic [4*NUM_CH-1:0] Config_C;
    logic                UserCLKo;
    logic [FBPR-1:0]     FrameData, FrameData_O;
    logic [MFPC-1:0]     FrameStrobe, FrameStrobe_O;

    int passed = 0;
    int total  = 0;

    logic [FBPR-1:0]   frames [NF];
    logic [NUM_CH-1:0] xh1 = '0, xh2 = '0, xh3 = '0;
    logic [NUM_CH-1:0] dprev = '0, tprev = '0;
    logic [OW-1:0]     eb;

    w_io_multi #(
        .NUM_CH          (NUM_CH),
        .FrameBitsPerRow (FBPR),
        .MaxFramesPerCol (MFPC),
        .CFG_BITS_PER_CH (12)
    ) dut (
        .UserCLK       (UserCLK),
        .UserRST_n     (UserRST_n),
        .pad_O         (pad_O),
        .pad_I         (pad_I),
        .pad_T         (pad_T),
        .fab_I         (fab_I),
        .fab_T         (fab_T),
        .fab_O         (fab_O),
        .Config_C      (Config_C),
        .UserCLKo      (UserCLKo),
        .FrameData     (FrameData),
        .FrameData_O   (FrameData_O),
        .FrameStrobe   (FrameStrobe),
        .FrameStrobe_O (FrameStrobe_O)
    );

    always #5 UserCLK = ~UserCLK;

    function automatic logic [11:0] chan_cfg(input int c);
        logic [11:0] w;
        int b;
        for (int i = 0; i < 12; i++) begin
            b = 12*c + i;
            w[i] = frames[b / FBPR][b % FBPR];
        end
        return w;
    endfunction

    // Expected {pad_I, pad_T, fab_O, Config_C} for the current inputs.
    function automatic logic [OW-1:0] exp_bus();
        logic [NUM_CH-1:0]   pi, pt, fo;
        logic [4*NUM_CH-1:0] cc;
        logic [11:0]         w;
        logic                x, d;
        for (int c = 0; c < NUM_CH; c++) begin
            w = chan_cfg(c);
            x = pad_O[c] ^ w[5];
            d = fab_I[c] ^ w[4];
            pi[c] = w[0] ? dprev[c] : d;
            pt[c] = w[6] ? 1'b0 : (w[1] ? tprev[c] : fab_T[c]);
            case (w[3:2])
                2'd0:    fo[c] = x;
                2'd1:    fo[c] = xh1[c];
                2'd2:    fo[c] = xh2[c];
                default: fo[c] = xh2[c] & ~xh3[c];
            endcase
            cc[4*c +: 4] = w[11:8];
        end
        if (!UserRST_n) begin
            pi = '0;
            pt = '1;
            fo = '0;
            cc = '0;
        end
        return {pi, pt, fo, cc};
    endfunction

    task automatic model_edge();
        logic [11:0] w;
        if (!UserRST_n) begin
            foreach (frames[f]) frames[f] = '0;
            xh1 = '0;
            xh2 = '0;
            xh3 = '0;
            dprev = '0;
            tprev = '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                w = chan_cfg(c);
                xh3[c] = xh2[c];
                xh2[c] = xh1[c];
                xh1[c] = pad_O[c] ^ w[5];
                dprev[c] = fab_I[c] ^ w[4];
                tprev[c] = fab_T[c];
            end
            for (int f = 0; f < NF; f++)
                if (FrameStrobe[f]) frames[f] = FrameData;
        end
    endtask

    task automatic tick();
        @(posedge UserCLK);
        model_edge();
        #1;
    endtask

    task automatic load(input logic [MFPC-1:0] mask, input logic [FBPR-1:0] data);
        FrameStrobe = mask;
        FrameData   = data;
        tick();
        FrameStrobe = '0;
    endtask

    task automatic rand_in();
        pad_O = NUM_CH'($urandom);
        fab_I = NUM_CH'($urandom);
        fab_T = NUM_CH'($urandom);
    endtask

    task automatic test_reset();
        UserRST_n   = 1'b0;
        FrameStrobe = '0;
        FrameData   = '0;
        fab_T = '0;
        fab_I = '1;
        pad_O = '1;
        tick();
        tick();
        #1;
        total++;
        if (pad_T !== '1) $display("FAIL reset_pad_t: got %h exp %h", pad_T, 4'hF);
        else passed++;
        total++;
        if (pad_I !== '0) $display("FAIL reset_pad_i: got %h exp 0", pad_I);
        else passed++;
        total++;
        if (fab_O !== '0) $display("FAIL reset_fab_o: got %h exp 0", fab_O);
        else passed++;
        total++;
        if (Config_C !== '0) $display("FAIL reset_cfgc: got %h exp 0", Config_C);
        else passed++;
        UserRST_n = 1'b1;
        #1;
        total++;
        if (pad_T !== fab_T) $display("FAIL release_pad_t: got %h exp %h", pad_T, fab_T);
        else passed++;
        eb = exp_bus();
        total++;
        if ({pad_I, pad_T, fab_O, Config_C} !== eb)
            $display("FAIL release_bus: got %h exp %h", {pad_I, pad_T, fab_O, Config_C}, eb);
        else passed++;
        tick();
    endtask

    task automatic test_frame_load();
        logic prev = 1'b0;
        fab_T = '1;
        load(20'h1, 32'h0000_0F41);
        #1;
        total++;
        if (Config_C[3:0] !== 4'hF) $display("FAIL load_cfgc: got %h exp f", Config_C[3:0]);
        else passed++;
        total++;
        if (pad_T[0] !== 1'b0) $display("FAIL load_oe_force: got %b exp 0", pad_T[0]);
        else passed++;
        for (int i = 0; i < 8; i++) begin
            fab_I = NUM_CH'($urandom);
            pad_O = NUM_CH'($urandom);
            #1;
            if (i > 0) begin
                total++;
                if (pad_I[0] !== prev) $display("FAIL out_reg: got %b exp %b", pad_I[0], prev);
                else passed++;
            end
            eb = exp_bus();
            total++;
            if ({pad_I, pad_T, fab_O, Config_C} !== eb)
                $display("FAIL load_bus: got %h exp %h", {pad_I, pad_T, fab_O, Config_C}, eb);
            else passed++;
            prev = fab_I[0];
            tick();
        end
        load(20'h20, $urandom);
        #1;
        total++;
        if (Config_C !== 16'h000F) $display("FAIL unused_strobe: got %h exp 000f", Config_C);
        else passed++;
    endtask

    task automatic test_input_modes();
        int lat, pulses, exp_lat;
        for (int m = 0; m < 4; m++) begin
            load(20'h1, 32'(m) << 2);
            for (int i = 0; i < 4; i++) begin
                rand_in();
                pad_O[0] = 1'b0;
                tick();
            end
            pad_O[0] = 1'b1;
            lat = -1;
            pulses = 0;
            for (int k = 0; k < 6; k++) begin
                #1;
                eb = exp_bus();
                total++;
                if ({pad_I, pad_T, fab_O, Config_C} !== eb)
                    $display("FAIL mode%0d_bus: got %h exp %h", m, {pad_I, pad_T, fab_O, Config_C}, eb);
                else passed++;
                if (fab_O[0] && lat < 0) lat = k;
                pulses += int'(fab_O[0]);
                tick();
                pad_O[3:1] = 3'($urandom);
            end
            exp_lat = (m == 0) ? 0 : (m == 1) ? 1 : 2;
            total++;
            if (lat != exp_lat) $display("FAIL mode%0d_latency: got %0d exp %0d", m, lat, exp_lat);
            else passed++;
            if (m == 3) begin
                total++;
                if (pulses != 1) $display("FAIL edge_pulses: got %0d exp 1", pulses);
                else passed++;
            end
        end
    endtask

    task automatic test_inversion();
        load(20'h1, 32'h24);
        pad_O[0] = 1'b0;
        tick();
        #1;
        total++;
        if (fab_O[0] !== 1'b1) $display("FAIL inv_in: got %b exp 1", fab_O[0]);
        else passed++;
        load(20'h1, 32'h10);
        fab_I[0] = 1'b1;
        #1;
        total++;
        if (pad_I[0] !== 1'b0) $display("FAIL inv_out: got %b exp 0", pad_I[0]);
        else passed++;
        eb = exp_bus();
        total++;
        if ({pad_I, pad_T, fab_O, Config_C} !== eb)
            $display("FAIL inv_bus: got %h exp %h", {pad_I, pad_T, fab_O, Config_C}, eb);
        else passed++;
    endtask

    task automatic test_simultaneous();
        logic [FBPR-1:0] data;
        UserRST_n = 1'b0;
        load(20'h1, $urandom | 32'h0000_0F00);
        UserRST_n = 1'b1;
        #1;
        total++;
        if (Config_C !== '0) $display("FAIL rst_vs_strobe: got %h exp 0", Config_C);
        else passed++;
        data = $urandom;
        load(20'h3, data);
        #1;
        total++;
        if (Config_C[3:0] !== data[11:8])
            $display("FAIL dual_f0: got %h exp %h", Config_C[3:0], data[11:8]);
        else passed++;
        total++;
        if (Config_C[11:8] !== data[3:0])
            $display("FAIL dual_f1: got %h exp %h", Config_C[11:8], data[3:0]);
        else passed++;
        eb = exp_bus();
        total++;
        if ({pad_I, pad_T, fab_O, Config_C} !== eb)
            $display("FAIL dual_bus: got %h exp %h", {pad_I, pad_T, fab_O, Config_C}, eb);
        else passed++;
    endtask

    task automatic test_mode_change();
        load(20'h1, 32'h2 << 14);
        for (int i = 0; i < 12; i++) begin
            rand_in();
            if (i == 6) begin
                FrameStrobe = 20'h1;
                FrameData   = '0;
            end
            #1;
            if (i > 6) begin
                total++;
                if (fab_O[1] !== pad_O[1]) $display("FAIL switch_comb: got %b exp %b", fab_O[1], pad_O[1]);
                else passed++;
            end
            eb = exp_bus();
            total++;
            if ({pad_I, pad_T, fab_O, Config_C} !== eb)
                $display("FAIL switch_bus: got %h exp %h", {pad_I, pad_T, fab_O, Config_C}, eb);
            else passed++;
            tick();
            FrameStrobe = '0;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_in();
            UserRST_n = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 5) == 0) begin
                FrameStrobe = MFPC'($urandom);
                FrameData   = $urandom;
            end else begin
                FrameStrobe = '0;
            end
            #1;
            eb = exp_bus();
            total++;
            if ({pad_I, pad_T, fab_O, Config_C} !== eb)
                $display("FAIL random_bus: cyc %0d got %h exp %h", i, {pad_I, pad_T, fab_O, Config_C}, eb);
            else passed++;
            tick();
        end
        UserRST_n   = 1'b1;
        FrameStrobe = '0;
    endtask

    task automatic test_passthrough();
        for (int i = 0; i < 6; i++) begin
            UserRST_n   = i[0];
            FrameData   = $urandom;
            FrameStrobe = MFPC'($urandom);
            #1;
            total++;
            if (FrameData_O !== FrameData || FrameStrobe_O !== FrameStrobe)
                $display("FAIL passthru: got %h/%h exp %h/%h",
                         FrameData_O, FrameStrobe_O, FrameData, FrameStrobe);
            else passed++;
            total++;
            if (UserCLKo !== UserCLK) $display("FAIL clk_passthru: got %b exp %b", UserCLKo, UserCLK);
            else passed++;
            #4;
            total++;
            if (UserCLKo !== UserCLK) $display("FAIL clk_passthru_hi: got %b exp %b", UserCLKo, UserCLK);
            else passed++;
            tick();
        end
        UserRST_n   = 1'b1;
        FrameStrobe = '0;
    endtask

    initial begin
        foreach (frames[f]) frames[f] = '0;
        test_reset();
        test_frame_load();
        test_input_modes();
        test_inversion();
        test_simultaneous();
        test_mode_change();
        test_random();
        test_passthrough();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
